// File: rtl/mag_arb_seq.sv
// Two-requester round-robin front end sharing one iterative engine: res = floor(sqrt(x*x + y*y)).
// Latency: result valid after handshake edge + W+2; a held result blocks new grants until consumed.
module mag_arb_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] a_x,
    input  logic [W-1:0] a_y,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [W-1:0] b_x,
    input  logic [W-1:0] b_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   res_mag,
    output logic         res_id,
    output logic         busy
);
    localparam int SW = 2 * W + 2;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W);

    typedef enum logic [1:0] {IDLE, SQ, ROOT, DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;
    logic          r_id;
    logic          r_last_b;
    logic [SW-1:0] r_sum;
    logic [W+2:0]  r_rem;
    logic [W:0]    r_root;
    logic [CW-1:0] r_cnt;

    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_ge;
    logic [2*W:0]  w_sq;
    logic [W+4:0]  w_rem_sh;
    logic [W+4:0]  w_trial;

    // On a tie the requester not served last wins; r_last_b = 1 means B was served last.
    assign w_grant_a = a_valid && (!b_valid || r_last_b);
    assign w_grant_b = b_valid && (!a_valid || !r_last_b);

    assign w_sq = {{(W + 1){1'b0}}, r_x} * {{(W + 1){1'b0}}, r_x}
                + {{(W + 1){1'b0}}, r_y} * {{(W + 1){1'b0}}, r_y};

    // One restoring step: bring down the next bit pair, try subtracting 4*root+1.
    assign w_rem_sh = {r_rem, r_sum[SW-1:SW-2]};
    assign w_trial  = {2'b00, r_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                a_ready = w_grant_a && !rst;
                b_ready = w_grant_b && !rst;
                if (a_ready || b_ready) begin
                    w_state_nxt = SQ;
                end
            end
            SQ:   w_state_nxt = ROOT;
            ROOT: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_id     <= 1'b0;
            r_last_b <= 1'b1;
            r_sum    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (a_ready) begin
                        r_x      <= a_x;
                        r_y      <= a_y;
                        r_id     <= 1'b0;
                        r_last_b <= 1'b0;
                    end else if (b_ready) begin
                        r_x      <= b_x;
                        r_y      <= b_y;
                        r_id     <= 1'b1;
                        r_last_b <= 1'b1;
                    end
                end
                SQ: begin
                    r_sum  <= {1'b0, w_sq};
                    r_rem  <= '0;
                    r_root <= '0;
                    r_cnt  <= '0;
                end
                ROOT: begin
                    r_sum  <= {r_sum[SW-3:0], 2'b00};
                    r_rem  <= w_ge ? (w_rem_sh[W+2:0] - w_trial[W+2:0]) : w_rem_sh[W+2:0];
                    r_root <= {r_root[W-1:0], w_ge};
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (r_state == DONE);
    assign res_mag   = r_root;
    assign res_id    = r_id;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mag_arb_seq.sv
// Bench for mag_arb_seq: directed vector table, multi-cycle corner sequences, and a randomized
// two-requester run scored against an integer-sqrt reference with per-requester ordering queues.
module tb_mag_arb_seq;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_x;
    logic [W-1:0] a_y;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_x;
    logic [W-1:0] b_y;
    logic         res_valid;
    logic         res_ready;
    logic [W:0]   res_mag;
    logic         res_id;
    logic         busy;

    int checks;
    int failures;

    typedef struct {
        int id;
        int x;
        int y;
        int mag;
    } vec_t;

    vec_t tbl[11];

    mag_arb_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_x       (a_x),
        .a_y       (a_y),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_x       (b_x),
        .b_y       (b_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_mag   (res_mag),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1; a_valid = 1; b_valid = 1; res_ready = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_a_ready", int'(a_ready), 0);
        chk("rst_b_ready", int'(b_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_mag", int'(res_mag), 0);
        chk("rst_res_id", int'(res_id), 0);
        @(posedge clk); #1;
        rst = 0; a_valid = 0; b_valid = 0;
    endtask

    task automatic drain;
        bit idle;
        idle = 0;
        res_ready = 1;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        chk("drain_idle", int'(idle), 1);
    endtask

    task automatic wait_ready(input int id, input string name);
        bit hs;
        hs = 0;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            if (id != 0 ? b_ready : a_ready) hs = 1;
        end
        chk(name, int'(hs), 1);
    endtask

    task automatic run_one(input int id, input int x, input int y, input int exp_mag);
        bit got;
        @(posedge clk); #1;
        res_ready = 1;
        if (id != 0) begin b_valid = 1; b_x = 8'(x); b_y = 8'(y); end
        else         begin a_valid = 1; a_x = 8'(x); a_y = 8'(y); end
        wait_ready(id, "handshake");
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1;
                chk("latency", k, 10);
                chk("res_mag", int'(res_mag), exp_mag);
                chk("res_id", int'(res_id), id);
            end
        end
        chk("result_seen", int'(got), 1);
        @(negedge clk);
        chk("res_valid_one_cycle", int'(res_valid), 0);
    endtask

    initial begin
        int g[4];
        int rm[4];
        int ri[4];
        int ng, nr, both, seen, hmag;
        int qa[$];
        int qb[$];
        int ax, ay, bx, by, a_iss, b_iss, nres, last_g, unfair, exp;
        bit a_pend, b_pend, got;

        checks = 0; failures = 0;
        clk = 0; rst = 1; a_valid = 0; b_valid = 0; res_ready = 0;
        a_x = 0; a_y = 0; b_x = 0; b_y = 0;

        tbl[0]  = '{0, 6, 8, 10};
        tbl[1]  = '{0, 10, 10, 14};
        tbl[2]  = '{1, 5, 10, 11};
        tbl[3]  = '{0, 255, 255, 360};
        tbl[4]  = '{1, 0, 0, 0};
        tbl[5]  = '{0, 0, 16, 16};
        tbl[6]  = '{1, 3, 4, 5};
        tbl[7]  = '{0, 255, 0, 255};
        tbl[8]  = '{1, 12, 5, 13};
        tbl[9]  = '{0, 1, 1, 1};
        tbl[10] = '{1, 20, 21, 29};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_one(tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].mag);
        end

        // Both requesters held valid after reset: A first, then strict alternation.
        do_reset();
        @(posedge clk); #1;
        a_x = 3; a_y = 4; b_x = 8; b_y = 15;
        a_valid = 1; b_valid = 1; res_ready = 1;
        ng = 0; nr = 0; both = 0;
        for (int i = 0; i < 4; i++) begin g[i] = -1; rm[i] = -1; ri[i] = -1; end
        for (int c = 0; c < 200 && nr < 4; c++) begin
            @(negedge clk);
            if (a_ready && b_ready) both++;
            if (ng < 4 && a_ready) begin g[ng] = 0; ng++; end
            else if (ng < 4 && b_ready) begin g[ng] = 1; ng++; end
            if (res_valid && res_ready) begin rm[nr] = int'(res_mag); ri[nr] = int'(res_id); nr++; end
        end
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        chk("tie_both_ready", both, 0);
        chk("tie_results", nr, 4);
        for (int i = 0; i < 4; i++) begin
            chk("tie_grant_order", g[i], i % 2);
            chk("tie_res_id", ri[i], i % 2);
            chk("tie_res_mag", rm[i], (i % 2 == 1) ? 17 : 5);
        end
        drain();

        // Result stalled 20+ cycles: outputs frozen, no grants, grant right after release.
        @(posedge clk); #1;
        res_ready = 0; a_x = 6; a_y = 8; a_valid = 1;
        wait_ready(0, "stall_handshake");
        @(posedge clk); #1;
        b_x = 3; b_y = 4; b_valid = 1;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (res_valid) got = 1;
        end
        chk("stall_result_seen", int'(got), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_res_valid", int'(res_valid), 1);
            chk("stall_res_mag", int'(res_mag), 10);
            chk("stall_res_id", int'(res_id), 0);
            chk("stall_a_ready", int'(a_ready), 0);
            chk("stall_b_ready", int'(b_ready), 0);
        end
        @(posedge clk); #1;
        res_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_b_ready", int'(b_ready), 1);
        chk("release_a_ready", int'(a_ready), 0);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        got = 0; hmag = -1; seen = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (res_valid) begin got = 1; hmag = int'(res_mag); seen = int'(res_id); end
        end
        chk("release_b_mag", hmag, 5);
        chk("release_b_id", seen, 1);
        drain();

        // Reset pulse during ROOT abandons the operation.
        @(posedge clk); #1;
        res_ready = 1; a_x = 12; a_y = 5; a_valid = 1;
        wait_ready(0, "abort_handshake");
        @(posedge clk); #1;
        a_valid = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_mag", int'(res_mag), 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        run_one(0, 12, 5, 13);

        // Randomized traffic against the reference model.
        a_pend = 0; b_pend = 0; a_iss = 0; b_iss = 0; nres = 0; last_g = -1; unfair = 0;
        ax = 0; ay = 0; bx = 0; by = 0;
        for (int c = 0; c < 60000 && nres < 2000; c++) begin
            @(posedge clk); #1;
            if (!a_pend) begin
                a_valid = 0;
                if (a_iss < 1000 && $urandom_range(0, 2) == 0) begin
                    ax = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
                    ay = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
                    a_x = 8'(ax); a_y = 8'(ay); a_valid = 1; a_pend = 1;
                end
            end
            if (!b_pend) begin
                b_valid = 0;
                if (b_iss < 1000 && $urandom_range(0, 2) == 0) begin
                    bx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
                    by = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
                    b_x = 8'(bx); b_y = 8'(by); b_valid = 1; b_pend = 1;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (a_valid && a_ready) begin
                if (b_valid && last_g == 0) unfair++;
                last_g = 0;
                qa.push_back(isqrt(ax * ax + ay * ay));
                a_pend = 0; a_iss++;
            end
            if (b_valid && b_ready) begin
                if (a_valid && last_g == 1) unfair++;
                last_g = 1;
                qb.push_back(isqrt(bx * bx + by * by));
                b_pend = 0; b_iss++;
            end
            if (res_valid && res_ready) begin
                nres++;
                if (res_id == 1'b0) begin
                    exp = (qa.size() > 0) ? qa.pop_front() : -1;
                    chk("rand_mag_a", int'(res_mag), exp);
                end else begin
                    exp = (qb.size() > 0) ? qb.pop_front() : -1;
                    chk("rand_mag_b", int'(res_mag), exp);
                end
            end
        end
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        chk("rand_result_count", nres, 2000);
        chk("rand_left_a", qa.size(), 0);
        chk("rand_left_b", qb.size(), 0);
        chk("rand_fairness", unfair, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
